// File: rtl/at24c04_eeprom.sv
// -----------------------------------------------------------------------------
// at24c04_eeprom
//   Behavioural-synthesizable model of a 4 Kbit (512 x 8) I2C serial EEPROM in
//   the AT24C04 style: device addressing with A2/A1 chip select and P0 as word
//   address bit 8, 16-byte page writes with in-page address wrap, current,
//   random and sequential reads, write protect and a timed internal write
//   cycle during which the device NACKs its address (ACK polling).
//
// Ports
//   clk_i     in   system clock, all logic on its rising edge
//   rst_i     in   synchronous active-high reset (array contents are kept)
//   scl_i     in   I2C clock from the bus (asynchronous to clk_i)
//   sda_i     in   I2C data as seen on the bus (asynchronous to clk_i)
//   sda_oe_o  out  1 = pull SDA low, 0 = release (open drain)
//   wp_i      in   write protect, 1 = array is read-only
//
// Parameters
//   DEV_A21     chip-select bits compared against device-address bits 3:2
//   TWR_CYCLES  internal write-cycle length in clk_i cycles (must be >= 16,
//               the page is committed one entry per cycle at its start)
// -----------------------------------------------------------------------------
module at24c04_eeprom #(
    parameter logic [1:0] DEV_A21    = 2'b00,
    parameter int         TWR_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_oe_o,
    input  logic wp_i
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        DEV       = 4'd1,
        DEV_ACK   = 4'd2,
        WADDR     = 4'd3,
        WADDR_ACK = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        MACK      = 4'd8
    } state_t;

    localparam logic [15:0] TWR_LAST = 16'(TWR_CYCLES - 1);

    // Device-address match: fixed 1010 family code plus chip-select pins.
    function automatic logic dev_match(input logic [7:0] b);
        return (b[7:4] == 4'b1010) && (b[3:2] == DEV_A21);
    endfunction

    // Bus synchronizers and edge history
    logic scl_meta_r, scl_sync_r, scl_prev_r;
    logic sda_meta_r, sda_sync_r, sda_prev_r;
    logic scl_rise_s, scl_fall_s, start_s, stop_s;

    // FSM
    state_t state_r, state_nx;
    logic   sda_oe_r, sda_oe_nx;

    // Datapath
    logic [3:0]  bit_cnt_r;
    logic [7:0]  shift_r;
    logic [7:0]  out_r;
    logic        mack_r;
    logic [8:0]  addr_r;
    logic [8:0]  addr_inc_s;
    logic [7:0]  page_buf_r [0:15];
    logic [15:0] valid_r;
    logic        busy_r;
    logic [15:0] twr_r;
    logic [4:0]  page_r;
    logic        bit8_s;
    logic        wr_en_s;
    logic [7:0]  rd_byte_s;
    logic [7:0]  rd_next_s;

    // The array holds complemented data so its all-zero power-up state reads
    // back as erased (0xFF) without any initialisation sequence.
    logic [7:0]  mem_r [0:511];

    assign sda_oe_o   = sda_oe_r;
    assign scl_rise_s = scl_sync_r & ~scl_prev_r;
    assign scl_fall_s = ~scl_sync_r & scl_prev_r;
    assign start_s    = scl_sync_r & scl_prev_r & sda_prev_r & ~sda_sync_r;
    assign stop_s     = scl_sync_r & scl_prev_r & ~sda_prev_r & sda_sync_r;
    assign bit8_s     = (bit_cnt_r == 4'd8);
    assign addr_inc_s = addr_r + 9'd1;
    assign rd_byte_s  = ~mem_r[addr_r];
    assign rd_next_s  = ~mem_r[addr_inc_s];
    assign wr_en_s    = busy_r && (twr_r < 16'd16) && valid_r[twr_r[3:0]];

    // Two-flop synchronizers plus one history flop; reset to idle-high bus.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            scl_prev_r <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_meta_r <= scl_i;
            scl_sync_r <= scl_meta_r;
            scl_prev_r <= scl_sync_r;
            sda_meta_r <= sda_i;
            sda_sync_r <= sda_meta_r;
            sda_prev_r <= sda_sync_r;
        end
    end

    // FSM state and SDA driver registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= IDLE;
            sda_oe_r <= 1'b0;
        end else begin
            state_r  <= state_nx;
            sda_oe_r <= sda_oe_nx;
        end
    end

    // Next-state and SDA drive; SDA only moves on SCL falling, START or STOP.
    always_comb begin
        state_nx  = state_r;
        sda_oe_nx = sda_oe_r;
        if (start_s) begin
            state_nx  = DEV;
            sda_oe_nx = 1'b0;
        end else if (stop_s) begin
            state_nx  = IDLE;
            sda_oe_nx = 1'b0;
        end else if (scl_fall_s) begin
            case (state_r)
                DEV: begin
                    if (bit8_s && dev_match(shift_r) && !busy_r) begin
                        state_nx  = DEV_ACK;
                        sda_oe_nx = 1'b1;
                    end else if (bit8_s) begin
                        state_nx  = IDLE;
                        sda_oe_nx = 1'b0;
                    end else begin
                        state_nx  = DEV;
                    end
                end
                DEV_ACK: begin
                    // The R/W bit is still in the receive shifter here.
                    if (shift_r[0]) begin
                        state_nx  = RDATA;
                        sda_oe_nx = ~rd_byte_s[7];
                    end else begin
                        state_nx  = WADDR;
                        sda_oe_nx = 1'b0;
                    end
                end
                WADDR: begin
                    if (bit8_s) begin
                        state_nx  = WADDR_ACK;
                        sda_oe_nx = 1'b1;
                    end else begin
                        state_nx  = WADDR;
                    end
                end
                WADDR_ACK: begin
                    state_nx  = WDATA;
                    sda_oe_nx = 1'b0;
                end
                WDATA: begin
                    if (bit8_s) begin
                        state_nx  = WDATA_ACK;
                        sda_oe_nx = 1'b1;
                    end else begin
                        state_nx  = WDATA;
                    end
                end
                WDATA_ACK: begin
                    state_nx  = WDATA;
                    sda_oe_nx = 1'b0;
                end
                RDATA: begin
                    // bit_cnt counts bits already sampled by the master.
                    if (bit8_s) begin
                        state_nx  = MACK;
                        sda_oe_nx = 1'b0;
                    end else begin
                        sda_oe_nx = ~out_r[3'd7 - bit_cnt_r[2:0]];
                    end
                end
                MACK: begin
                    if (mack_r) begin
                        state_nx  = RDATA;
                        sda_oe_nx = ~rd_next_s[7];
                    end else begin
                        state_nx  = IDLE;
                        sda_oe_nx = 1'b0;
                    end
                end
                IDLE: begin
                    state_nx  = IDLE;
                    sda_oe_nx = 1'b0;
                end
                default: begin
                    state_nx  = IDLE;
                    sda_oe_nx = 1'b0;
                end
            endcase
        end else begin
            state_nx = state_r;
        end
    end

    // Bit/byte datapath, address counter, page buffer and write-cycle timer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'h00;
            out_r     <= 8'h00;
            mack_r    <= 1'b0;
            addr_r    <= 9'd0;
            valid_r   <= 16'h0000;
            busy_r    <= 1'b0;
            twr_r     <= 16'd0;
            page_r    <= 5'd0;
        end else begin
            if (busy_r) begin
                if (twr_r == TWR_LAST) begin
                    busy_r  <= 1'b0;
                    valid_r <= 16'h0000;
                end
                twr_r <= twr_r + 16'd1;
            end

            if (start_s) begin
                bit_cnt_r <= 4'd0;
                // An unfinished write is abandoned by a (repeated) START.
                if (!busy_r) begin
                    valid_r <= 16'h0000;
                end
            end else if (stop_s) begin
                bit_cnt_r <= 4'd0;
                if (!busy_r && (state_r == WDATA || state_r == WDATA_ACK) &&
                    (|valid_r) && !wp_i) begin
                    busy_r <= 1'b1;
                    twr_r  <= 16'd0;
                    page_r <= addr_r[8:4];
                end else if (!busy_r) begin
                    valid_r <= 16'h0000;
                end
            end else if (scl_rise_s) begin
                case (state_r)
                    DEV, WADDR, WDATA: begin
                        shift_r   <= {shift_r[6:0], sda_sync_r};
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                    end
                    RDATA:   bit_cnt_r <= bit_cnt_r + 4'd1;
                    MACK:    mack_r    <= ~sda_sync_r;
                    default: mack_r    <= mack_r;
                endcase
            end else if (scl_fall_s) begin
                case (state_r)
                    DEV: begin
                        if (bit8_s && dev_match(shift_r) && !busy_r) begin
                            addr_r[8] <= shift_r[1];
                        end
                    end
                    DEV_ACK: begin
                        bit_cnt_r <= 4'd0;
                        out_r     <= rd_byte_s;
                    end
                    WADDR: begin
                        if (bit8_s) begin
                            addr_r[7:0] <= shift_r;
                        end
                    end
                    WDATA: begin
                        if (bit8_s) begin
                            page_buf_r[addr_r[3:0]] <= shift_r;
                            valid_r[addr_r[3:0]]    <= 1'b1;
                            addr_r[3:0]             <= addr_r[3:0] + 4'd1;
                        end
                    end
                    WADDR_ACK, WDATA_ACK: bit_cnt_r <= 4'd0;
                    MACK: begin
                        addr_r    <= addr_inc_s;
                        bit_cnt_r <= 4'd0;
                        out_r     <= rd_next_s;
                    end
                    default: bit_cnt_r <= bit_cnt_r;
                endcase
            end
        end
    end

    // Commit one valid page-buffer entry per cycle at the start of the write cycle
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_r[{page_r, twr_r[3:0]}] <= ~page_buf_r[twr_r[3:0]];
        end
    end

endmodule

// File: tb/tb_at24c04_eeprom.sv
module tb_at24c04_eeprom;

    localparam int TWR = 400;

    typedef enum logic [2:0] {OP_START, OP_STOP, OP_WR, OP_RDA, OP_RDN, OP_WAIT, OP_WP} op_e;

    typedef struct {
        op_e        op;
        logic [7:0] data;
        logic [7:0] exp;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic sda_m = 1'b1;
    logic wp = 1'b0;
    logic sda_oe;
    logic sda_bus;
    logic mon_en = 1'b0;
    logic oe_seen = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    vec_t vecs[$];

    assign sda_bus = sda_m & ~sda_oe;

    at24c04_eeprom #(.DEV_A21(2'b00), .TWR_CYCLES(TWR)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .scl_i   (scl),
        .sda_i   (sda_bus),
        .sda_oe_o(sda_oe),
        .wp_i    (wp)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && sda_oe) oe_seen <= 1'b1;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(5);
        scl = 1'b1;   wait_clk(10);
        sda_m = 1'b0; wait_clk(10);
        scl = 1'b0;   wait_clk(5);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(5);
        scl = 1'b1;   wait_clk(10);
        sda_m = 1'b1; wait_clk(10);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; wait_clk(5);
            scl = 1'b1;   wait_clk(10);
            scl = 1'b0;   wait_clk(5);
        end
        sda_m = 1'b1; wait_clk(5);
        scl = 1'b1;   wait_clk(5);
        ack = ~sda_bus;
        wait_clk(5);
        scl = 1'b0;   wait_clk(5);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; wait_clk(5);
            scl = 1'b1;   wait_clk(5);
            d[i] = sda_bus;
            wait_clk(5);
            scl = 1'b0;   wait_clk(5);
        end
        sda_m = master_ack ? 1'b0 : 1'b1; wait_clk(5);
        scl = 1'b1; wait_clk(10);
        scl = 1'b0; wait_clk(5);
    endtask

    function automatic void add(input op_e op, input logic [7:0] d, input logic [7:0] e, input string n);
        vec_t v;
        v.op = op; v.data = d; v.exp = e; v.name = n;
        vecs.push_back(v);
    endfunction

    function automatic void wr(input logic [7:0] d, input logic ack, input string n);
        add(OP_WR, d, {7'd0, ack}, n);
    endfunction

    initial begin
        logic       ack;
        logic [7:0] d;

        // Byte write then random read
        add(OP_START, 8'h00, 8'h00, "");
        wr(8'hA0, 1'b1, "bw_dev"); wr(8'h05, 1'b1, "bw_addr"); wr(8'h5A, 1'b1, "bw_data");
        add(OP_STOP, 8'h00, 8'h00, ""); add(OP_WAIT, 8'h00, 8'h00, "");
        add(OP_START, 8'h00, 8'h00, "");
        wr(8'hA0, 1'b1, "rr_dev"); wr(8'h05, 1'b1, "rr_addr");
        add(OP_START, 8'h00, 8'h00, ""); wr(8'hA1, 1'b1, "rr_devr");
        add(OP_RDN, 8'h00, 8'h5A, "rr_data_005"); add(OP_STOP, 8'h00, 8'h00, "");
        // Page wrap
        add(OP_START, 8'h00, 8'h00, "");
        wr(8'hA0, 1'b1, "pw_dev"); wr(8'h0E, 1'b1, "pw_addr");
        wr(8'h11, 1'b1, "pw_d0"); wr(8'h22, 1'b1, "pw_d1"); wr(8'h33, 1'b1, "pw_d2");
        add(OP_STOP, 8'h00, 8'h00, ""); add(OP_WAIT, 8'h00, 8'h00, "");
        add(OP_START, 8'h00, 8'h00, ""); wr(8'hA0, 1'b1, "pr_dev"); wr(8'h0E, 1'b1, "pr_addr");
        add(OP_START, 8'h00, 8'h00, ""); wr(8'hA1, 1'b1, "pr_devr");
        add(OP_RDA, 8'h00, 8'h11, "pr_00e"); add(OP_RDN, 8'h00, 8'h22, "pr_00f");
        add(OP_STOP, 8'h00, 8'h00, "");
        add(OP_START, 8'h00, 8'h00, ""); wr(8'hA1, 1'b1, "cur_devr");
        add(OP_RDN, 8'h00, 8'hFF, "cur_010_unchanged"); add(OP_STOP, 8'h00, 8'h00, "");
        add(OP_START, 8'h00, 8'h00, ""); wr(8'hA0, 1'b1, "p0_dev"); wr(8'h00, 1'b1, "p0_addr");
        add(OP_START, 8'h00, 8'h00, ""); wr(8'hA1, 1'b1, "p0_devr");
        add(OP_RDN, 8'h00, 8'h33, "pr_000_wrapped"); add(OP_STOP, 8'h00, 8'h00, "");
        // Sequential read across 0x1FF -> 0x000
        add(OP_START, 8'h00, 8'h00, "");
        wr(8'hA2, 1'b1, "hi_dev"); wr(8'hFF, 1'b1, "hi_addr"); wr(8'h9C, 1'b1, "hi_data");
        add(OP_STOP, 8'h00, 8'h00, ""); add(OP_WAIT, 8'h00, 8'h00, "");
        add(OP_START, 8'h00, 8'h00, ""); wr(8'hA2, 1'b1, "sr_dev"); wr(8'hFF, 1'b1, "sr_addr");
        add(OP_START, 8'h00, 8'h00, ""); wr(8'hA3, 1'b1, "sr_devr");
        add(OP_RDA, 8'h00, 8'h9C, "sr_1ff"); add(OP_RDA, 8'h00, 8'h33, "sr_000");
        add(OP_RDN, 8'h00, 8'hFF, "sr_001"); add(OP_STOP, 8'h00, 8'h00, "");
        // Write protect: bytes ACKed, no busy, array unchanged
        add(OP_WP, 8'h01, 8'h00, "");
        add(OP_START, 8'h00, 8'h00, "");
        wr(8'hA0, 1'b1, "wp_dev"); wr(8'h20, 1'b1, "wp_addr"); wr(8'h77, 1'b1, "wp_data");
        add(OP_STOP, 8'h00, 8'h00, "");
        add(OP_START, 8'h00, 8'h00, ""); wr(8'hA0, 1'b1, "wp_nobusy_dev"); wr(8'h20, 1'b1, "wp_raddr");
        add(OP_START, 8'h00, 8'h00, ""); wr(8'hA1, 1'b1, "wp_devr");
        add(OP_RDN, 8'h00, 8'hFF, "wp_020_kept"); add(OP_STOP, 8'h00, 8'h00, "");
        add(OP_WP, 8'h00, 8'h00, "");
        // ACK polling during a write cycle
        add(OP_START, 8'h00, 8'h00, "");
        wr(8'hA0, 1'b1, "ap_dev"); wr(8'h40, 1'b1, "ap_addr"); wr(8'h66, 1'b1, "ap_data");
        add(OP_STOP, 8'h00, 8'h00, "");
        add(OP_START, 8'h00, 8'h00, ""); wr(8'hA0, 1'b0, "ap_busy_nack");
        add(OP_STOP, 8'h00, 8'h00, ""); add(OP_WAIT, 8'h00, 8'h00, "");
        add(OP_START, 8'h00, 8'h00, ""); wr(8'hA0, 1'b1, "ap_ready_ack"); wr(8'h40, 1'b1, "ap_raddr");
        add(OP_START, 8'h00, 8'h00, ""); wr(8'hA1, 1'b1, "ap_devr");
        add(OP_RDN, 8'h00, 8'h66, "ap_040"); add(OP_STOP, 8'h00, 8'h00, "");

        // Reset state
        wait_clk(10);
        check("reset_sda_oe", {7'd0, sda_oe}, 8'h00);
        rst = 1'b0;
        wait_clk(10);
        check("idle_sda_oe", {7'd0, sda_oe}, 8'h00);

        // Directed table
        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_START: i2c_start();
                OP_STOP:  i2c_stop();
                OP_WR: begin
                    write_byte(vecs[i].data, ack);
                    check(vecs[i].name, {7'd0, ack}, vecs[i].exp);
                end
                OP_RDA: begin
                    read_byte(1'b1, d);
                    check(vecs[i].name, d, vecs[i].exp);
                end
                OP_RDN: begin
                    read_byte(1'b0, d);
                    check(vecs[i].name, d, vecs[i].exp);
                end
                OP_WAIT: wait_clk(TWR + 50);
                OP_WP:   wp = vecs[i].data[0];
                default: wait_clk(1);
            endcase
        end

        // Address mismatch: NACK and SDA never pulled through the following STOP
        mon_en = 1'b1;
        i2c_start();
        write_byte(8'hA4, ack);
        check("mm_dev_nack", {7'd0, ack}, 8'h00);
        write_byte(8'h00, ack);
        check("mm_next_nack", {7'd0, ack}, 8'h00);
        i2c_stop();
        mon_en = 1'b0;
        check("mm_oe_seen", {7'd0, oe_seen}, 8'h00);

        // Reset clears the address counter but keeps the array
        rst = 1'b1; wait_clk(5);
        rst = 1'b0; wait_clk(5);
        i2c_start();
        write_byte(8'hA1, ack);
        check("rst_cur_devr", {7'd0, ack}, 8'h01);
        read_byte(1'b0, d);
        check("rst_cur_000", d, 8'h33);
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h05, ack);
        i2c_start();
        write_byte(8'hA1, ack);
        check("rst_kept_devr", {7'd0, ack}, 8'h01);
        read_byte(1'b0, d);
        check("rst_kept_005", d, 8'h5A);
        i2c_stop();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/at24c04_eeprom.md
AT24C04_EEPROM -- requirements
Module: at24c04_eeprom

Interface
REQ-001 Parameter DEV_A21, 2'b00, chip-select address bits A2:A1 compared against device-address bits 3:2.
REQ-002 Parameter TWR_CYCLES, 64, internal write-cycle length in clk_i cycles.
REQ-003 clk_i  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 scl_i  input  1  I2C clock from bus; asynchronous to clk_i.
REQ-006 sda_i  input  1  I2C data as seen on the bus; asynchronous to clk_i.
REQ-007 sda_oe_o  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 wp_i  input  1  write protect; 1 = the whole array is read-only.

Function
REQ-009 Storage SHALL be 512 x 8 bits; word address is 9 bits, with bit 8 taken from device-address bit 1 (P0).
REQ-010 scl_i and sda_i SHALL each pass through a 2-flop synchronizer; edge and condition detection SHALL use only the synchronized values.
REQ-011 START condition: SDA falls while SCL is high. STOP condition: SDA rises while SCL is high. Both SHALL be honoured in any state, including mid-byte.
REQ-012 Bits SHALL be sampled on SCL rising, MSB first; sda_oe_o SHALL change only after SCL falling, or on STOP/START.
REQ-013 FSM states: IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, MACK.
REQ-014 START from any state SHALL go to DEV with the bit counter cleared; this also covers repeated START.
REQ-015 DEV matches when byte[7:4]==4'b1010 and byte[3:2]==DEV_A21.
  - Mismatch, or a write cycle in progress: go to IDLE, SDA released (NACK).
  - Match: ACK (drive low for the 9th SCL pulse); set addr[8]=byte[1].
  - R/W=0: go to WADDR. R/W=1: go to RDATA.
REQ-016 WADDR: after 8 bits set addr[7:0]=byte, ACK, then go to WDATA.
REQ-017 WDATA: each received byte SHALL be ACKed and stored in a 16-byte page buffer at addr[3:0].
  - addr[3:0] increments and wraps 15->0 within the page; addr[8:4] is unchanged.
  - Bytes beyond 16 overwrite earlier buffer entries.
REQ-018 STOP after at least one WDATA byte with wp_i==0 SHALL start the write cycle.
  - Buffered bytes are committed to the array; only the locations actually written change.
  - The device is busy for TWR_CYCLES clk_i cycles.
REQ-019 STOP with wp_i==1 SHALL discard the page buffer; data bytes are still ACKed.
REQ-020 STOP in WADDR or WADDR_ACK (dummy write) SHALL leave the array unchanged and keep the loaded address.
REQ-021 RDATA: drive mem[addr] MSB first, with sda_oe_o = ~bit; then release SDA during the master ACK bit (MACK).
  - Master ACK (SDA low): addr increments modulo 512 (0x1FF->0x000) and RDATA continues.
  - Master NACK: addr increments, then IDLE.
REQ-022 The address counter SHALL persist between transactions (current-address read); a write leaves it at last written address+1 within the page wrap.
REQ-023 Byte write SHALL be a page write of length 1.

Reset
REQ-024 rst_i SHALL force the following values:
  - state=IDLE, sda_oe_o=0, addr=0, busy=0;
  - bit counter and page-buffer valid flags cleared.
REQ-025 rst_i SHALL NOT clear array contents; array initial contents are 0xFF.
REQ-026 Reset during a write cycle SHALL abort the commit; no partial page write is guaranteed.

Verification
REQ-027 Byte write then random read:
  - Write A0, 05, 5A, STOP; wait TWR_CYCLES.
  - Send A0, 05, repeated START, A1, read with NACK -> 0x5A; all earlier bytes ACKed.
REQ-028 Page wrap:
  - Write A0, 0E, then 0x11,0x22,0x33, STOP.
  - Read 0x00E..0x00F and 0x000 -> 11, 22, 33; 0x010 is unchanged (FF).
REQ-029 Sequential read wrap:
  - Set addr via A2, FF, repeated START, A3; read 3 bytes with ACK, ACK, NACK -> mem[1FF], mem[000], mem[001].
REQ-030 Address mismatch: A4 with DEV_A21=00 -> NACK, sda_oe_o stays 0 through the next STOP.
REQ-031 ACK polling: A0 sent during a write cycle -> NACK; the same byte sent after TWR_CYCLES -> ACK.
REQ-032 Write protect: wp_i=1, write A0, 20, 77, STOP -> all bytes ACKed; a later read of 0x020 returns the prior value and no busy period occurs.
